uart_rx_byte_receiver: RTL and testbench
========================================

Name: uart_rx_byte_receiver

Overview:
- Serial-to-parallel UART receiver, 8N1 format, LSB first, oversampled by the system clock.
- Sits directly upstream of the UART-to-SRAM loader.
- Presents one byte at a time through a single-entry buffer using an Empty/Unload_data handshake.
- Reports overrun and a saturating count of framing errors.

Parameters:
- CLKS_PER_BIT, 434, system clocks per bit period (50 MHz / 115200 baud); must be even, 4 or more.
- SYNC_STAGES, 2, flip-flop stages on UART_RX_I before any use.

Ports:
- Clock_50  in  1  system clock; all logic on its rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- Enable  in  1  1 = receive; 0 = FSM held in IDLE.
- Unload_data  in  1  consumer acknowledge; only its rising edge is acted on.
- RX_data  out  8  last accepted byte.
- Empty  out  1  1 = no unread byte in the buffer.
- Overrun  out  1  sticky: a byte completed while the buffer was full.
- Frame_error  out  4  saturating count of framing errors.
- UART_RX_I  in  1  serial line, idle high, asynchronous to Clock_50.

Behaviour:
- Reset values (Resetn=0, asynchronous): RX_data=8'h00, Empty=1, Overrun=0, Frame_error=0, FSM=IDLE, synchronizer flops=1, internal counters=0.
- Line input: UART_RX_I passes through SYNC_STAGES flops. "rx_s" is the synchronized value; only rx_s is used.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: if Enable=1 and rx_s=0, load bit counter with CLKS_PER_BIT/2-1, go to START.
- START: at counter 0, sample rx_s.
  - rx_s=1: glitch; return to IDLE, no flags change.
  - rx_s=0: reload CLKS_PER_BIT-1, bit index=0, go to DATA.
- DATA: at each counter 0, shift rx_s into bit[index] (LSB first) and reload. After index 7 is sampled, go to STOP.
- STOP: at counter 0, sample rx_s.
  - rx_s=1: commit the byte, go to IDLE.
  - rx_s=0: Frame_error += 1, saturating at 4'hF; byte discarded; go to WAIT_HIGH.
- WAIT_HIGH: stay until rx_s=1, then go to IDLE. This avoids false starts on a break.
- Latency: for a clean frame whose start edge reaches the pin at cycle 0, the commit edge is cycle SYNC_STAGES + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT. Empty reads 0 from the cycle after that commit edge (79 cycles at CLKS_PER_BIT=8).
- Commit when Empty=1: RX_data <= byte, Empty <= 0.
- Commit when Empty=0 and no unload edge this cycle: byte discarded, RX_data unchanged, Overrun <= 1.
- Unload: a rising edge of Unload_data (registered previous value) while Empty=0 sets Empty <= 1 on the next clock edge.
  - Holding Unload_data high has no further effect.
  - A rising edge while Empty=1 is ignored.
- Simultaneous unload edge and commit: the unload wins that cycle (Empty <= 1). The new byte is held in a pending register and loaded on the following edge (RX_data <= byte, Empty <= 0). No overrun is recorded.
- A second commit while a byte is pending cannot occur (it needs at least 10*CLKS_PER_BIT cycles).
- Enable=0 (any state, including mid-frame):
  - FSM -> IDLE next edge; partial byte and pending byte discarded.
  - Empty <= 1, Overrun <= 0; RX_data retained.
- Frame_error is cleared on the rising edge of Enable (0->1) and by reset only.
- Asynchronous reset mid-frame: all state returns immediately to the reset values above.

Test Plan:
- CLKS_PER_BIT=8, Enable=1, send 0xA5 cleanly -> Empty falls at cycle 79 after the start edge, RX_data=8'hA5, Overrun=0, Frame_error=0.
- Unload_data rising edge, held high 20 cycles -> Empty=1 one cycle later and stays 1. Send 0x3C -> Empty=0, RX_data=8'h3C.
- Start pulse low for 3 cycles only, then line high -> FSM returns to IDLE, Empty stays 1, all flags 0. A following 0x5A is received correctly.
- Send 0x81 with stop bit low, then hold line low 40 cycles -> Frame_error=1, Empty=1, no new start until the line returns high. Repeat 17 times -> Frame_error saturates at 4'hF.
- Send 0x11, do not unload, send 0x22 -> RX_data=8'h11, Overrun=1. Then send 0x33 with the unload edge on the exact commit cycle -> Empty=1 for one cycle, then Empty=0, RX_data=8'h33, Overrun stays 1 (sticky).
- Drop Enable during bit 4 of 0xF0 -> FSM IDLE, Empty=1, Overrun=0. Re-enable and send 0x0F -> RX_data=8'h0F. Assert Resetn=0 mid-frame -> all outputs return to reset values at once.

Source files
------------

// File: rtl/uart_rx_byte_receiver.sv
// uart_rx_byte_receiver: 8N1 UART receiver, oversampled by Clock_50,
// with a single-entry output buffer, overrun flag and framing-error count.
module uart_rx_byte_receiver #(
   parameter int CLKS_PER_BIT = 434,
   parameter int SYNC_STAGES  = 2
) (
   input  logic       Clock_50,
   input  logic       Resetn,
   input  logic       Enable,
   input  logic       Unload_data,
   output logic [7:0] RX_data,
   output logic       Empty,
   output logic       Overrun,
   output logic [3:0] Frame_error,
   input  logic       UART_RX_I
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] ONE     = CW'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_WAIT_HIGH
   } state_t;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rx_s;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    sh_q, sh_d;
   logic          commit;
   logic          ferr;

   logic [7:0] data_q;
   logic [7:0] pend_q;
   logic       pend_vld_q;
   logic       empty_q;
   logic       ovr_q;
   logic [3:0] fe_q;
   logic       en_q;
   logic       unl_q;
   logic       unload_edge;

   assign rx_s        = sync_q[SYNC_STAGES-1];
   assign unload_edge = Unload_data & ~unl_q;

   // Metastability synchronizer for the asynchronous serial line
   always_ff @(posedge Clock_50 or negedge Resetn) begin
      if (!Resetn) begin
         sync_q <= '1;
      end else begin
         sync_q[0] <= UART_RX_I;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   // Receiver FSM state, bit-period counter, bit index and shift register
   always_ff @(posedge Clock_50 or negedge Resetn) begin
      if (!Resetn) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         sh_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         sh_q    <= sh_d;
      end
   end

   // Next-state logic: sample mid-bit, flag a commit or a framing error
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      sh_d    = sh_q;
      commit  = 1'b0;
      ferr    = 1'b0;
      if (!Enable) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         idx_d   = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (!rx_s) begin
                  cnt_d   = HALF_M1;
                  state_d = S_START;
               end
            end
            S_START: begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - ONE;
               end else if (rx_s) begin
                  state_d = S_IDLE;
               end else begin
                  cnt_d   = FULL_M1;
                  idx_d   = 3'd0;
                  state_d = S_DATA;
               end
            end
            S_DATA: begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - ONE;
               end else begin
                  sh_d[idx_q] = rx_s;
                  cnt_d       = FULL_M1;
                  if (idx_q == 3'd7) begin
                     state_d = S_STOP;
                  end else begin
                     idx_d = idx_q + 3'd1;
                  end
               end
            end
            S_STOP: begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - ONE;
               end else if (rx_s) begin
                  commit  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  ferr    = 1'b1;
                  state_d = S_WAIT_HIGH;
               end
            end
            S_WAIT_HIGH: begin
               if (rx_s) begin
                  state_d = S_IDLE;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // Output buffer: commit, unload handshake, pending byte, overrun, errors
   always_ff @(posedge Clock_50 or negedge Resetn) begin
      if (!Resetn) begin
         data_q     <= 8'h00;
         pend_q     <= 8'h00;
         pend_vld_q <= 1'b0;
         empty_q    <= 1'b1;
         ovr_q      <= 1'b0;
         fe_q       <= 4'h0;
         en_q       <= 1'b0;
         unl_q      <= 1'b0;
      end else begin
         en_q  <= Enable;
         unl_q <= Unload_data;
         if (!Enable) begin
            empty_q    <= 1'b1;
            ovr_q      <= 1'b0;
            pend_vld_q <= 1'b0;
         end else if (pend_vld_q) begin
            data_q     <= pend_q;
            empty_q    <= 1'b0;
            pend_vld_q <= 1'b0;
         end else if (commit) begin
            if (empty_q) begin
               data_q  <= sh_q;
               empty_q <= 1'b0;
            end else if (unload_edge) begin
               empty_q    <= 1'b1;
               pend_q     <= sh_q;
               pend_vld_q <= 1'b1;
            end else begin
               ovr_q <= 1'b1;
            end
         end else if (unload_edge && !empty_q) begin
            empty_q <= 1'b1;
         end
         if (Enable && !en_q) begin
            fe_q <= 4'h0;
         end else if (ferr && fe_q != 4'hF) begin
            fe_q <= fe_q + 4'd1;
         end
      end
   end

   assign RX_data     = data_q;
   assign Empty       = empty_q;
   assign Overrun     = ovr_q;
   assign Frame_error = fe_q;

endmodule

// File: tb/tb_uart_rx_byte_receiver.sv
// tb_uart_rx_byte_receiver: vector table plus scoreboard of received
// bytes, with hand-written sequences for timing-sensitive corner cases.
module tb_uart_rx_byte_receiver;

   logic       clk = 1'b0;
   logic       resetn;
   logic       enable;
   logic       unload;
   logic       rx_line;
   logic [7:0] rx_data;
   logic       empty;
   logic       overrun;
   logic [3:0] fe;

   int checks = 0;
   int errors = 0;

   logic [7:0] sb_q[$];
   logic [7:0] sb_exp;
   logic       empty_prev = 1'b1;

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic [3:0] fe;
   } vec_t;

   vec_t tbl[6];

   always #5 clk = ~clk;

   uart_rx_byte_receiver #(
      .CLKS_PER_BIT(8),
      .SYNC_STAGES (2)
   ) dut (
      .Clock_50   (clk),
      .Resetn     (resetn),
      .Enable     (enable),
      .Unload_data(unload),
      .RX_data    (rx_data),
      .Empty      (empty),
      .Overrun    (overrun),
      .Frame_error(fe),
      .UART_RX_I  (rx_line)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Serial frame: start, 8 data bits LSB first, stop, optional low hold
   task automatic send_frame(input logic [7:0] d, input logic stop,
                             input int hold);
      @(negedge clk);
      rx_line = 1'b0;
      repeat (8) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_line = d[i];
         repeat (8) @(negedge clk);
      end
      rx_line = stop;
      repeat (8) @(negedge clk);
      if (!stop) repeat (hold) @(negedge clk);
      rx_line = 1'b1;
      repeat (16) @(negedge clk);
   endtask

   task automatic unload_pulse();
      @(negedge clk);
      unload = 1'b1;
      @(posedge clk);
      #1;
      chk("unload_empty", empty, 1);
      @(negedge clk);
      unload = 1'b0;
   endtask

   // Scoreboard: every byte presented by the DUT must be the next expected
   always @(negedge clk) begin
      if (empty_prev && !empty) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: got %0h expected none", rx_data);
         end else begin
            sb_exp = sb_q.pop_front();
            chk("sb_byte", rx_data, sb_exp);
         end
      end
      empty_prev = empty;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{data: 8'h00, stop: 1'b1, fe: 4'd0};
      tbl[1] = '{data: 8'hFF, stop: 1'b1, fe: 4'd0};
      tbl[2] = '{data: 8'h81, stop: 1'b0, fe: 4'd1};
      tbl[3] = '{data: 8'hC3, stop: 1'b1, fe: 4'd1};
      tbl[4] = '{data: 8'h7E, stop: 1'b0, fe: 4'd2};
      tbl[5] = '{data: 8'h01, stop: 1'b1, fe: 4'd2};

      resetn  = 1'b0;
      enable  = 1'b1;
      unload  = 1'b0;
      rx_line = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_data", rx_data, 8'h00);
      chk("rst_empty", empty, 1);
      chk("rst_ovr", overrun, 0);
      chk("rst_fe", fe, 0);
      resetn = 1'b1;
      repeat (4) @(negedge clk);

      // 0xA5 with exact commit latency
      sb_q.push_back(8'hA5);
      fork
         send_frame(8'hA5, 1'b1, 0);
         begin
            @(negedge clk);
            repeat (78) @(posedge clk);
            #1;
            chk("lat_empty77", empty, 1);
            @(posedge clk);
            #1;
            chk("lat_empty78", empty, 0);
         end
      join
      chk("a5_data", rx_data, 8'hA5);
      chk("a5_ovr", overrun, 0);
      chk("a5_fe", fe, 0);

      // Unload held high; level must not re-trigger on 0x3C
      @(negedge clk);
      unload = 1'b1;
      @(posedge clk);
      #1;
      chk("hold_unload", empty, 1);
      for (int i = 0; i < 19; i++) begin
         @(posedge clk);
         #1;
         chk("hold_empty", empty, 1);
      end
      sb_q.push_back(8'h3C);
      send_frame(8'h3C, 1'b1, 0);
      chk("3c_empty", empty, 0);
      @(negedge clk);
      unload = 1'b0;
      repeat (3) @(negedge clk);
      chk("3c_kept", empty, 0);
      chk("3c_data", rx_data, 8'h3C);
      unload_pulse();

      // Start glitch of 3 cycles
      @(negedge clk);
      rx_line = 1'b0;
      repeat (3) @(negedge clk);
      rx_line = 1'b1;
      repeat (30) @(negedge clk);
      chk("glitch_empty", empty, 1);
      chk("glitch_ovr", overrun, 0);
      chk("glitch_fe", fe, 0);
      sb_q.push_back(8'h5A);
      send_frame(8'h5A, 1'b1, 0);
      chk("5a_data", rx_data, 8'h5A);
      unload_pulse();

      // Table-driven frames
      for (int i = 0; i < 6; i++) begin
         if (tbl[i].stop) sb_q.push_back(tbl[i].data);
         send_frame(tbl[i].data, tbl[i].stop, 40);
         chk("tbl_fe", fe, tbl[i].fe);
         chk("tbl_empty", empty, !tbl[i].stop);
         if (tbl[i].stop) unload_pulse();
      end

      // Frame_error clear on Enable rising, then saturation
      @(negedge clk);
      enable = 1'b0;
      repeat (2) @(negedge clk);
      enable = 1'b1;
      repeat (2) @(negedge clk);
      chk("fe_clear", fe, 0);
      for (int n = 1; n <= 17; n++) begin
         send_frame(8'h81, 1'b0, 40);
         chk("fe_count", fe, (n > 15) ? 15 : n);
      end
      chk("fe_empty", empty, 1);

      // Overrun, then unload on the exact commit cycle
      sb_q.push_back(8'h11);
      send_frame(8'h11, 1'b1, 0);
      send_frame(8'h22, 1'b1, 0);
      chk("ovr_data", rx_data, 8'h11);
      chk("ovr_flag", overrun, 1);
      chk("ovr_empty", empty, 0);
      sb_q.push_back(8'h33);
      fork
         send_frame(8'h33, 1'b1, 0);
         begin
            @(negedge clk);
            repeat (78) @(posedge clk);
            @(negedge clk);
            unload = 1'b1;
            @(posedge clk);
            #1;
            chk("sim_empty1", empty, 1);
            @(posedge clk);
            #1;
            chk("sim_empty0", empty, 0);
            chk("sim_data", rx_data, 8'h33);
            chk("sim_ovr", overrun, 1);
            @(negedge clk);
            unload = 1'b0;
         end
      join

      // Enable dropped during bit 4 of 0xF0
      fork
         send_frame(8'hF0, 1'b1, 0);
         begin
            @(negedge clk);
            repeat (44) @(negedge clk);
            enable = 1'b0;
            @(posedge clk);
            #1;
            chk("dis_empty", empty, 1);
            chk("dis_ovr", overrun, 0);
            chk("dis_data", rx_data, 8'h33);
         end
      join
      @(negedge clk);
      enable = 1'b1;
      repeat (4) @(negedge clk);
      sb_q.push_back(8'h0F);
      send_frame(8'h0F, 1'b1, 0);
      chk("0f_data", rx_data, 8'h0F);
      send_frame(8'h81, 1'b0, 10);
      chk("pre_rst_fe", fe, 1);

      // Asynchronous reset mid-frame
      fork
         send_frame(8'h55, 1'b1, 0);
         begin
            @(negedge clk);
            repeat (30) @(negedge clk);
            #2;
            resetn = 1'b0;
            #1;
            chk("arst_data", rx_data, 8'h00);
            chk("arst_empty", empty, 1);
            chk("arst_ovr", overrun, 0);
            chk("arst_fe", fe, 0);
         end
      join
      @(negedge clk);
      resetn = 1'b1;
      repeat (20) @(negedge clk);
      chk("post_rst_empty", empty, 1);
      chk("sb_drain", sb_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
